// File: rtl/mem_access_stage.sv
// MEM pipeline stage: latches EX results, runs one load/store on the addr_ok/data_ok bus,
// aligns load data and hands results to WB. Optional MEM_ALIGN_CHECK_EN adds mem_ale.
//
//   state | meaning
//   IDLE  | no bus activity (empty, or holding a non-mem op)
//   REQ   | data_req asserted, waiting for data_addr_ok
//   WAIT  | request accepted, waiting for data_data_ok
//   DONE  | mem result held until WB accepts it
module mem_access_stage #(
  parameter int ADDR_W   = 32,
  parameter int MEM_OP_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_to_mem_valid,
  output logic                mem_allowin,
  input  logic [31:0]         ex_alu_result,
  input  logic [31:0]         ex_mem_wdata,
  input  logic [MEM_OP_W-1:0] ex_mem_op,
  input  logic [31:0]         ex_pc,
  input  logic [4:0]          ex_rf_waddr,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [3:0]          data_wstrb,
  output logic [31:0]         data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [31:0]         data_rdata,
  output logic                mem_to_wb_valid,
  input  logic                wb_allowin,
  output logic [31:0]         mem_pc,
  output logic                mem_rf_we,
  output logic [4:0]          mem_rf_waddr,
  output logic [31:0]         mem_rf_wdata,
  output logic                mem_valid
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                mem_ale
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state, state_nxt;

  logic                valid_r;
  logic [31:0]         alu_r;
  logic [31:0]         wdata_r;
  logic [31:0]         pc_r;
  logic [31:0]         rdata_r;
  logic [MEM_OP_W-1:0] op_r;
  logic [4:0]          waddr_r;

  logic       is_mem, is_store, is_load, is_uns;
  logic [1:0] size_eff;
  logic [1:0] lane;
  logic       accept;
  logic       ready_go;
  logic       ex_misalign;
  logic       ale;
  state_t     mem_tgt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  function automatic logic misalign(input logic [1:0] sz, input logic [1:0] a);
    return ((sz == 2'd1) & a[0]) | (sz[1] & (a != 2'd0));
  endfunction

  assign is_mem   = op_r[4];
  assign is_store = is_mem & op_r[3];
  assign is_load  = is_mem & ~op_r[3];
  assign is_uns   = op_r[2];
  assign size_eff = (op_r[1:0] == 2'd3) ? 2'd2 : op_r[1:0];
  assign lane     = alu_r[1:0];

  assign ready_go    = valid_r & (~is_mem | (state == DONE));
  assign mem_allowin = ~valid_r | (ready_go & wb_allowin);
  assign accept      = ex_to_mem_valid & mem_allowin;

`ifdef MEM_ALIGN_CHECK_EN
  // Misaligned ops skip the bus entirely and retire as a non-writing result.
  assign ex_misalign = misalign(ex_mem_op[1:0], ex_alu_result[1:0]);
  assign ale         = valid_r & is_mem & misalign(op_r[1:0], lane);
  assign mem_ale     = ale;
`else
  assign ex_misalign = 1'b0;
  assign ale         = 1'b0;
`endif

  assign mem_tgt = ex_misalign ? DONE : REQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept & ex_mem_op[4]) state_nxt = mem_tgt;
      REQ:  if (data_addr_ok) state_nxt = WAIT;
      WAIT: if (data_data_ok) state_nxt = DONE;
      DONE: if (wb_allowin) state_nxt = (accept & ex_mem_op[4]) ? mem_tgt : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      alu_r   <= '0;
      wdata_r <= '0;
      pc_r    <= '0;
      op_r    <= '0;
      waddr_r <= '0;
      rdata_r <= '0;
    end else begin
      if (mem_allowin) valid_r <= ex_to_mem_valid;
      if (accept) begin
        alu_r   <= ex_alu_result;
        wdata_r <= ex_mem_wdata;
        pc_r    <= ex_pc;
        op_r    <= ex_mem_op;
        waddr_r <= ex_rf_waddr;
      end
      if ((state == WAIT) && data_data_ok) rdata_r <= data_rdata;
    end
  end

  // Lane selection uses the low address bits even when the access is misaligned.
  always_comb begin
    ld_byte = rdata_r[{lane, 3'b000} +: 8];
    ld_half = lane[1] ? rdata_r[31:16] : rdata_r[15:0];
    case (size_eff)
      2'd0:    ld_data = {{24{~is_uns & ld_byte[7]}}, ld_byte};
      2'd1:    ld_data = {{16{~is_uns & ld_half[15]}}, ld_half};
      default: ld_data = rdata_r;
    endcase
  end

  always_comb begin
    data_wstrb = 4'b0000;
    if (is_store) begin
      case (size_eff)
        2'd0:    data_wstrb = 4'b0001 << lane;
        2'd1:    data_wstrb = lane[1] ? 4'b1100 : 4'b0011;
        default: data_wstrb = 4'b1111;
      endcase
    end
  end

  always_comb begin
    case (size_eff)
      2'd0:    data_wdata = {4{wdata_r[7:0]}};
      2'd1:    data_wdata = {2{wdata_r[15:0]}};
      default: data_wdata = wdata_r;
    endcase
  end

  assign data_req  = (state == REQ);
  assign data_wr   = is_store;
  assign data_size = size_eff;
  assign data_addr = alu_r[ADDR_W-1:0];

  assign mem_to_wb_valid = ready_go;
  assign mem_valid       = valid_r;
  assign mem_pc          = pc_r;
  assign mem_rf_waddr    = waddr_r;
  assign mem_rf_we       = valid_r & ~is_store & (waddr_r != 5'd0) & ~ale;
  assign mem_rf_wdata    = is_load ? ld_data : alu_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table of single-op vectors plus hand-written
// sequences for WB backpressure, back-to-back mem ops, reset mid-transaction and alignment.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_to_mem_valid;
  logic        mem_allowin;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_mem_wdata;
  logic [4:0]  ex_mem_op;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rf_waddr;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_to_wb_valid;
  logic        wb_allowin;
  logic [31:0] mem_pc;
  logic        mem_rf_we;
  logic [4:0]  mem_rf_waddr;
  logic [31:0] mem_rf_wdata;
  logic        mem_valid;
`ifdef MEM_ALIGN_CHECK_EN
  logic        mem_ale;
`endif

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .ex_to_mem_valid(ex_to_mem_valid), .mem_allowin(mem_allowin),
    .ex_alu_result(ex_alu_result), .ex_mem_wdata(ex_mem_wdata), .ex_mem_op(ex_mem_op),
    .ex_pc(ex_pc), .ex_rf_waddr(ex_rf_waddr),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_to_wb_valid(mem_to_wb_valid), .wb_allowin(wb_allowin),
    .mem_pc(mem_pc), .mem_rf_we(mem_rf_we), .mem_rf_waddr(mem_rf_waddr),
    .mem_rf_wdata(mem_rf_wdata), .mem_valid(mem_valid)
`ifdef MEM_ALIGN_CHECK_EN
    , .mem_ale(mem_ale)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [4:0]  wa;
    logic [1:0]  e_size;
    logic [3:0]  e_strb;
    logic [31:0] e_bwd;
    logic        e_we;
    logic [31:0] e_rfd;
  } vec_t;

  vec_t vecs[12];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(input logic [4:0] op, input logic [31:0] alu, input logic [31:0] wd,
                              input logic [31:0] rd, input logic [4:0] wa, input logic [1:0] sz,
                              input logic [3:0] st, input logic [31:0] bwd, input logic we,
                              input logic [31:0] rfd);
    vec_t v;
    v.op = op; v.alu = alu; v.wd = wd; v.rd = rd; v.wa = wa;
    v.e_size = sz; v.e_strb = st; v.e_bwd = bwd; v.e_we = we; v.e_rfd = rfd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [4:0] op, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [31:0] pc, input logic [4:0] wa);
    ex_to_mem_valid = 1'b1;
    ex_mem_op = op; ex_alu_result = alu; ex_mem_wdata = wd; ex_pc = pc; ex_rf_waddr = wa;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] pc;
    pc = 32'h100 + idx * 4;
    wb_allowin = 1'b1;
    drive_op(v.op, v.alu, v.wd, pc, v.wa);
    #1;
    chk($sformatf("v%0d_allowin_idle", idx), {31'd0, mem_allowin}, 32'd1);
    step();
    ex_to_mem_valid = 1'b0;
    if (v.op[4]) begin
      for (int k = 0; k < 8 && !data_req; k++) step();
      chk($sformatf("v%0d_req", idx), {31'd0, data_req}, 32'd1);
      chk($sformatf("v%0d_size", idx), {30'd0, data_size}, {30'd0, v.e_size});
      chk($sformatf("v%0d_addr", idx), data_addr, v.alu);
      chk($sformatf("v%0d_wr", idx), {31'd0, data_wr}, {31'd0, v.op[3]});
      chk($sformatf("v%0d_wstrb", idx), {28'd0, data_wstrb}, {28'd0, v.e_strb});
      if (v.op[3]) chk($sformatf("v%0d_bwdata", idx), data_wdata, v.e_bwd);
      data_addr_ok = 1'b1;
      step();
      data_addr_ok = 1'b0;
      chk($sformatf("v%0d_req_wait", idx), {31'd0, data_req}, 32'd0);
      chk($sformatf("v%0d_allowin_wait", idx), {31'd0, mem_allowin}, 32'd0);
      chk($sformatf("v%0d_wbv_wait", idx), {31'd0, mem_to_wb_valid}, 32'd0);
      step();
      data_data_ok = 1'b1;
      data_rdata = v.rd;
      step();
      data_data_ok = 1'b0;
      data_rdata = 32'h0;
    end
    chk($sformatf("v%0d_wbv", idx), {31'd0, mem_to_wb_valid}, 32'd1);
    chk($sformatf("v%0d_rf_we", idx), {31'd0, mem_rf_we}, {31'd0, v.e_we});
    chk($sformatf("v%0d_rf_wdata", idx), mem_rf_wdata, v.e_rfd);
    chk($sformatf("v%0d_pc", idx), mem_pc, pc);
    step();
    chk($sformatf("v%0d_drained", idx), {31'd0, mem_to_wb_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(5'b00000, 32'h0000_1234, 32'h0,         32'h0,         5'd5,  2'd0, 4'h0, 32'h0,         1'b1, 32'h0000_1234);
    vecs[1]  = mk(5'b10000, 32'h0000_1003, 32'h0,         32'h80FF_FFFF, 5'd7,  2'd0, 4'h0, 32'h0,         1'b1, 32'hFFFF_FF80);
    vecs[2]  = mk(5'b10100, 32'h0000_1003, 32'h0,         32'h80FF_FFFF, 5'd7,  2'd0, 4'h0, 32'h0,         1'b1, 32'h0000_0080);
    vecs[3]  = mk(5'b11001, 32'h0000_2002, 32'h1234_BEEF, 32'h0,         5'd3,  2'd1, 4'hC, 32'hBEEF_BEEF, 1'b0, 32'h0000_2002);
    vecs[4]  = mk(5'b11000, 32'h0000_4001, 32'hFFFF_FF5A, 32'h0,         5'd2,  2'd0, 4'h2, 32'h5A5A_5A5A, 1'b0, 32'h0000_4001);
    vecs[5]  = mk(5'b10001, 32'h0000_5002, 32'h0,         32'h8001_1234, 5'd9,  2'd1, 4'h0, 32'h0,         1'b1, 32'hFFFF_8001);
    vecs[6]  = mk(5'b10101, 32'h0000_5000, 32'h0,         32'h8001_F234, 5'd9,  2'd1, 4'h0, 32'h0,         1'b1, 32'h0000_F234);
    vecs[7]  = mk(5'b10010, 32'h0000_6000, 32'h0,         32'hDEAD_BEEF, 5'd10, 2'd2, 4'h0, 32'h0,         1'b1, 32'hDEAD_BEEF);
    vecs[8]  = mk(5'b10011, 32'h0000_6004, 32'h0,         32'h0102_0304, 5'd11, 2'd2, 4'h0, 32'h0,         1'b1, 32'h0102_0304);
    vecs[9]  = mk(5'b11010, 32'h0000_7000, 32'h1234_5678, 32'h0,         5'd12, 2'd2, 4'hF, 32'h1234_5678, 1'b0, 32'h0000_7000);
    vecs[10] = mk(5'b00000, 32'h0000_0042, 32'h0,         32'h0,         5'd0,  2'd0, 4'h0, 32'h0,         1'b0, 32'h0000_0042);
    vecs[11] = mk(5'b10000, 32'h0000_1001, 32'h0,         32'h0000_7F00, 5'd13, 2'd0, 4'h0, 32'h0,         1'b1, 32'h0000_007F);

    rst = 1'b0;
    ex_to_mem_valid = 1'b0; ex_alu_result = '0; ex_mem_wdata = '0; ex_mem_op = '0;
    ex_pc = '0; ex_rf_waddr = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0; wb_allowin = 1'b1;

    repeat (3) step();
    chk("rst_req", {31'd0, data_req}, 32'd0);
    chk("rst_wbv", {31'd0, mem_to_wb_valid}, 32'd0);
    chk("rst_allowin", {31'd0, mem_allowin}, 32'd1);
    chk("rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_rf_we", {31'd0, mem_rf_we}, 32'd0);
    rst = 1'b1;
    repeat (2) step();
    chk("post_rst_req", {31'd0, data_req}, 32'd0);
    chk("post_rst_wbv", {31'd0, mem_to_wb_valid}, 32'd0);
    chk("post_rst_allowin", {31'd0, mem_allowin}, 32'd1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // WB backpressure on a load result, then a mem op accepted as WB frees up
    wb_allowin = 1'b0;
    drive_op(5'b10010, 32'h0000_6000, 32'h0, 32'h500, 5'd4);
    step();
    ex_to_mem_valid = 1'b0;
    chk("bp_req", {31'd0, data_req}, 32'd1);
    data_addr_ok = 1'b1; step(); data_addr_ok = 1'b0;
    repeat (3) begin
      chk("bp_stall_allowin", {31'd0, mem_allowin}, 32'd0);
      step();
    end
    data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; step(); data_data_ok = 1'b0; data_rdata = '0;
    drive_op(5'b10010, 32'h0000_6008, 32'h0, 32'h504, 5'd6);
    repeat (3) begin
      #1;
      chk("bp_wbv_held", {31'd0, mem_to_wb_valid}, 32'd1);
      chk("bp_allowin_low", {31'd0, mem_allowin}, 32'd0);
      chk("bp_rf_wdata", mem_rf_wdata, 32'hCAFE_F00D);
      chk("bp_pc", mem_pc, 32'h500);
      chk("bp_no_req", {31'd0, data_req}, 32'd0);
      step();
    end
    wb_allowin = 1'b1;
    #1;
    chk("bp_allowin_rise", {31'd0, mem_allowin}, 32'd1);
    step();
    ex_to_mem_valid = 1'b0;
    chk("b2b_req", {31'd0, data_req}, 32'd1);
    chk("b2b_addr", data_addr, 32'h0000_6008);
    chk("b2b_pc", mem_pc, 32'h504);
    chk("b2b_wbv", {31'd0, mem_to_wb_valid}, 32'd0);
    data_addr_ok = 1'b1; step(); data_addr_ok = 1'b0;
    data_data_ok = 1'b1; data_rdata = 32'h1122_3344; step(); data_data_ok = 1'b0; data_rdata = '0;
    chk("b2b_rf_wdata", mem_rf_wdata, 32'h1122_3344);
    chk("b2b_wbv", {31'd0, mem_to_wb_valid}, 32'd1);
    step();

    // Reset while WAIT, then a stale data_ok
    drive_op(5'b10010, 32'h0000_6010, 32'h0, 32'h600, 5'd8);
    step();
    ex_to_mem_valid = 1'b0;
    data_addr_ok = 1'b1; step(); data_addr_ok = 1'b0;
    rst = 1'b0;
    #2;
    chk("midrst_valid", {31'd0, mem_valid}, 32'd0);
    chk("midrst_allowin", {31'd0, mem_allowin}, 32'd1);
    rst = 1'b1;
    step();
    data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA; step(); data_data_ok = 1'b0; data_rdata = '0;
    chk("late_dok_wbv", {31'd0, mem_to_wb_valid}, 32'd0);
    chk("late_dok_req", {31'd0, data_req}, 32'd0);
    step();
    chk("late_dok_wbv2", {31'd0, mem_to_wb_valid}, 32'd0);
    chk("late_dok_valid", {31'd0, mem_valid}, 32'd0);

    // Misaligned word load
    drive_op(5'b10010, 32'h0000_3002, 32'h0, 32'h700, 5'd8);
    step();
    ex_to_mem_valid = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    wb_allowin = 1'b0;
    repeat (2) begin
      #1;
      chk("ale_flag", {31'd0, mem_ale}, 32'd1);
      chk("ale_no_req", {31'd0, data_req}, 32'd0);
      chk("ale_wbv", {31'd0, mem_to_wb_valid}, 32'd1);
      chk("ale_rf_we", {31'd0, mem_rf_we}, 32'd0);
      step();
    end
    wb_allowin = 1'b1;
    step();
    chk("ale_clear", {31'd0, mem_ale}, 32'd0);
    chk("ale_no_req_end", {31'd0, data_req}, 32'd0);
`else
    chk("mis_req", {31'd0, data_req}, 32'd1);
    chk("mis_addr", data_addr, 32'h0000_3002);
    data_addr_ok = 1'b1; step(); data_addr_ok = 1'b0;
    data_data_ok = 1'b1; data_rdata = 32'hAABB_CCDD; step(); data_data_ok = 1'b0; data_rdata = '0;
    chk("mis_rf_wdata", mem_rf_wdata, 32'hAABB_CCDD);
    chk("mis_rf_we", {31'd0, mem_rf_we}, 32'd1);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage and the downstream end of the EX->MEM valid/allowin handshake.
- Its `mem_allowin` output is the ready signal the EX stage register samples.
- Latches EX results and issues load/store requests on a two-phase data bus (addr_ok / data_ok).
- Aligns and extends load data, then hands results to WB with its own valid/allowin pair.

Parameters:
- ADDR_W, 32, data address width.
- MEM_OP_W, 5, width of the memory-op field: [4] is_mem, [3] store, [2] unsigned load, [1:0] size (0 byte, 1 half, 2 word, 3 reserved = word).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- ex_to_mem_valid  in  1  EX has an instruction for MEM.
- mem_allowin  out  1  MEM can accept this cycle (EX ready input).
- ex_alu_result  in  32  address for mem ops, else writeback value.
- ex_mem_wdata  in  32  store data (unaligned, low bytes significant).
- ex_mem_op  in  MEM_OP_W  memory-op field.
- ex_pc  in  32  instruction PC.
- ex_rf_waddr  in  5  destination register, 0 = no write.
- data_req  out  1  bus request.
- data_wr  out  1  1 = store.
- data_size  out  2  0/1/2 = 1/2/4 bytes.
- data_addr  out  ADDR_W  byte address.
- data_wstrb  out  4  byte enables.
- data_wdata  out  32  lane-replicated store data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response (read data valid / write done).
- data_rdata  in  32  read data.
- mem_to_wb_valid  out  1  result valid for WB.
- wb_allowin  in  1  WB can accept.
- mem_pc  out  32  PC of the held instruction.
- mem_rf_we  out  1  register-file write enable: valid, not a store, waddr != 0.
- mem_rf_waddr  out  5  destination register.
- mem_rf_wdata  out  32  writeback data.
- mem_valid  out  1  stage holds an instruction (hazard logic).

Behaviour:
- Reset (rst=0, async): state=IDLE; valid_r=0; all payload registers 0; every output 0 except `mem_allowin`=1.
- Accept: `ex_to_mem_valid & mem_allowin` latches the payload and sets valid_r.
  - Otherwise, when `mem_allowin`=1, valid_r is cleared.
  - Payload holds while not accepting.
- Ready and valid:
  - `ready_go` = valid_r & (~is_mem | state==DONE).
  - `mem_allowin` = ~valid_r | (ready_go & wb_allowin).
  - `mem_to_wb_valid` = ready_go.
- FSM:
  - IDLE: on acceptance of an is_mem op -> REQ next cycle.
  - REQ: `data_req`=1 with address, size and store fields stable; `data_addr_ok`=1 -> WAIT.
  - WAIT: `data_req`=0; `data_data_ok`=1 -> DONE, read data captured into a register.
  - DONE: held until `wb_allowin`. Then -> REQ if a new mem op is accepted the same cycle, else -> IDLE.
- Non-mem ops never leave IDLE. `mem_to_wb_valid` rises the cycle after acceptance (1-cycle latency).
- Minimum mem-op latency is 3 cycles: accept at N, addr_ok at N+1, data_ok at N+2, result valid at N+3.
- A `data_data_ok` arriving in the same cycle as `data_addr_ok` is illegal; the bench must not drive it.
- Store strobes, with a = addr[1:0]:
  - byte: wstrb = 1<<a, wdata = {4{b}}.
  - half: wstrb = 0011 or 1100 selected by a[1], wdata = {2{h}}.
  - word: wstrb = 1111.
- Loads: select the byte/half by addr[1:0], then sign- or zero-extend per bit [2]. `data_wstrb`=0 for loads.
- Writeback data: `mem_rf_wdata` = extended load data for loads, else `ex_alu_result`.
- Outstanding transactions: at most one. No new `data_req` until the prior `data_data_ok`.
- Bus stall: WAIT may last indefinitely. `mem_allowin` stays 0 throughout.
- Reset mid-transaction: FSM returns to IDLE immediately. A late `data_data_ok` arriving in IDLE is ignored.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - Adds output `mem_ale` (1 bit) = valid_r & is_mem & misaligned (half with addr[0]=1, or word with addr[1:0]!=0).
  - A misaligned op issues no `data_req`. It goes IDLE->DONE directly with `mem_rf_we`=0.
- Undefined: no `mem_ale` port; misaligned addresses are issued as-is with low address bits used for lane select only.

Test Plan:
- Reset held low, clk running -> `data_req`=0, `mem_to_wb_valid`=0, `mem_allowin`=1; release -> same values hold.
- Non-mem op, alu_result=0x1234, waddr=5, wb_allowin=1 -> next cycle `mem_to_wb_valid`=1, `mem_rf_we`=1, `mem_rf_wdata`=0x1234.
- Signed byte load at 0x1003, rdata=0x80FFFFFF, addr_ok immediate, data_ok after 2 cycles:
  - `data_size`=0, `data_addr`=0x1003.
  - `mem_rf_wdata`=0xFFFFFF80; unsigned variant gives 0x00000080.
- Half store 0xBEEF at 0x2002 -> `data_wr`=1, `data_wstrb`=1100, `data_wdata`=0xBEEFBEEF; WB sees `mem_rf_we`=0 after data_ok.
- Load result with wb_allowin=0 for 3 cycles -> `mem_to_wb_valid` held, `mem_allowin`=0, outputs stable; EX op accepted the cycle wb_allowin rises.
- rst pulsed low while in WAIT, then data_ok pulsed -> state IDLE, no `mem_to_wb_valid`.
  - With MEM_ALIGN_CHECK_EN: word load at 0x3002 -> `mem_ale`=1, no `data_req`.
